spi_slave_cfg: RTL and testbench
================================

SPI_SLAVE_CFG -- requirements
Module: spi_slave_cfg

Interface
REQ-001 The block SHALL have parameter P_DATA_W, default 8, giving the word width in bits (legal range 4..32).
REQ-002 The block SHALL have parameter P_CPOL, default 0, giving the SCK idle level.
REQ-003 The block SHALL have parameter P_CPHA, default 0: 0 samples on the leading edge, 1 samples on the trailing edge.
REQ-004 The block SHALL have parameter P_LSB_FIRST, default 0: 0 is MSB first, 1 is LSB first, for both MOSI and MISO.
REQ-005 The block SHALL have these ports:
  i_clk  in  1  system clock, 50 MHz
  i_rst  in  1  asynchronous active-high reset
  i_spi_s_sck  in  1  SPI SCK
  i_spi_s_cs_n  in  1  SPI chip select, active low
  i_spi_s_mosi  in  1  SPI MOSI
  o_spi_s_miso  out  1  SPI MISO
  o_spi_s_miso_oe  out  1  MISO output enable
  i_tx_data  in  P_DATA_W  next word to transmit
  i_tx_valid  in  1  i_tx_data valid
  o_tx_ready  out  1  TX holding register empty
  o_rx_data  out  P_DATA_W  received word
  o_rx_valid  out  1  o_rx_data valid
  i_rx_ready  in  1  consumer accepts o_rx_data
  o_rx_overrun  out  1  one-cycle pulse: received word dropped
  o_tx_underrun  out  1  one-cycle pulse: word start with TX holding register empty
  o_busy  out  1  CS asserted, after synchronisation

Function
REQ-006 SCK, CSn and MOSI SHALL each pass through a 2-FF synchroniser in i_clk. Edge detection SHALL use the last two synchronised SCK samples.
REQ-007 Edge names: the leading edge is the idle-to-active SCK transition (rising when P_CPOL=0); the trailing edge is the opposite transition. The sample edge is the leading edge if P_CPHA=0 and the trailing edge otherwise; the shift edge is the other one.
REQ-008 SCK edges SHALL be honoured only while synchronised CSn is 0. Supported SCK frequency SHALL be at most i_clk/8.
REQ-009 A bit counter of width clog2(P_DATA_W) SHALL increment on each sample edge. It SHALL wrap to 0 on the P_DATA_W-th sample edge, so back-to-back words run without CS deassertion.
REQ-010 On each sample edge, synchronised MOSI SHALL shift into the RX shift register: into the LSB side when P_LSB_FIRST=0, into the MSB side otherwise.
REQ-011 On the P_DATA_W-th sample edge, the completed word SHALL be pushed to the RX output stage, with o_rx_valid asserted the next i_clk cycle.
REQ-012 The RX handshake SHALL be: a word is consumed in the cycle where o_rx_valid=1 and i_rx_ready=1. o_rx_data SHALL be stable while o_rx_valid=1 and i_rx_ready=0.
REQ-013 A TX word SHALL be written into the holding register when i_tx_valid=1 and o_tx_ready=1. o_tx_ready SHALL be 1 whenever the holding register is empty.
REQ-014 On a word-start event (synchronised CSn falling, or the P_DATA_W-th sample edge), the TX shift register SHALL load the holding register and mark it empty. If the holding register is empty, it SHALL load all-zeros and pulse o_tx_underrun for 1 cycle.
REQ-015 MISO timing with P_CPHA=0:
  - At CSn falling, MISO SHALL present the first bit.
  - Each shift edge SHALL present the next bit.
  - After a word-boundary load, the next shift edge SHALL present the first bit of the new word.
REQ-016 MISO timing with P_CPHA=1: each shift edge SHALL present the next bit, with the first shift edge of a word presenting its first bit.
REQ-017 o_spi_s_miso_oe SHALL equal NOT synchronised CSn, tri-stating MISO when deselected. o_busy SHALL equal the same value.
REQ-018 CSn deassertion mid-word SHALL:
  - clear the bit counter;
  - discard the partial RX word (no push);
  - discard the partial TX shift word;
  - leave the holding register and RX stage untouched.
REQ-019 Simultaneous TX holding-register write and word-start load SHALL behave as follows: the load takes the old content (or zeros if empty), and the new word then occupies the holding register.

Reset
REQ-020 While i_rst=1, the block SHALL force these values:
  - SCK synchroniser to P_CPOL, CSn synchroniser to 1, MOSI synchroniser to 0;
  - counters to 0 and shift registers to 0;
  - holding register empty, RX stage empty;
  - o_spi_s_miso=0, o_spi_s_miso_oe=0, o_tx_ready=1, o_rx_valid=0, o_rx_data=0, o_rx_overrun=0, o_tx_underrun=0, o_busy=0.
REQ-021 Reset asserted mid-transfer SHALL abort the transfer. After release, the block SHALL ignore SCK until the next CSn falling edge.

Configuration
REQ-022 With macro SPI_SLAVE_CFG_RX_FIFO_EN defined, the RX stage SHALL be a 4-entry FIFO:
  - o_rx_valid means not empty, and o_rx_data is the head entry;
  - overrun occurs only when a push arrives while the FIFO is full and there is no pop that cycle;
  - a push and pop in the same cycle while full SHALL both succeed.
REQ-023 Without SPI_SLAVE_CFG_RX_FIFO_EN, the RX stage SHALL be a single register. A push while o_rx_valid=1 and i_rx_ready=0 SHALL drop the new word and pulse o_rx_overrun. A push coinciding with a consume SHALL succeed.

Verification
REQ-024 Defaults, i_tx_data=0x55 preloaded, master sends 0xAA -> o_rx_data=0xAA with a one-cycle o_rx_valid (i_rx_ready=1); master reads 0x55 on MISO.
REQ-025 P_CPOL=1, P_CPHA=1, P_DATA_W=16, P_LSB_FIRST=1, master sends 0x1234 -> o_rx_data=0x1234; MISO carries i_tx_data 0xBEEF LSB first.
REQ-026 Burst of 3 words under one CS with TX loaded only once -> first word transmitted; words 2 and 3 send 0x00, each with one o_tx_underrun pulse.
REQ-027 i_rx_ready=0, 5 words received -> without the macro: 1 word held and 4 o_rx_overrun pulses; with the macro: 4 words held and 1 pulse.
REQ-028 CSn raised after 5 bits, then a full 0xC3 word -> exactly one o_rx_valid with 0xC3, and the partial word is never output.
REQ-029 i_rst asserted after bit 3 of a word -> all outputs at their reset values within 1 cycle; the next full transfer after release is correct.

Source files
------------

// File: rtl/spi_slave_cfg.sv
// SPI slave with configurable mode, word width and bit order, TX holding register and RX output stage.
// Optional macro SPI_SLAVE_CFG_RX_FIFO_EN replaces the single RX register with a 4-entry FIFO.
module spi_slave_cfg #(
  parameter int P_DATA_W    = 8,
  parameter int P_CPOL      = 0,
  parameter int P_CPHA      = 0,
  parameter int P_LSB_FIRST = 0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_spi_s_sck,
  input  logic                i_spi_s_cs_n,
  input  logic                i_spi_s_mosi,
  output logic                o_spi_s_miso,
  output logic                o_spi_s_miso_oe,
  input  logic [P_DATA_W-1:0] i_tx_data,
  input  logic                i_tx_valid,
  output logic                o_tx_ready,
  output logic [P_DATA_W-1:0] o_rx_data,
  output logic                o_rx_valid,
  input  logic                i_rx_ready,
  output logic                o_rx_overrun,
  output logic                o_tx_underrun,
  output logic                o_busy
);

  localparam int   CNT_W = $clog2(P_DATA_W);
  localparam logic CPOL_L = (P_CPOL != 0);
  localparam logic CPHA_L = (P_CPHA != 0);
  localparam logic LSB_L  = (P_LSB_FIRST != 0);

  logic [1:0] sck_sync, cs_sync, mosi_sync;
  logic       sck_d, cs_d;
  logic       sck_s, cs_s, mosi_s;
  logic       sck_rise, sck_fall, lead_edge, trail_edge;
  logic       sample_edge, shift_edge, cs_fall;
  logic       last_bit, word_done, word_start, tx_write;

  logic [CNT_W-1:0]    bit_cnt;
  logic [P_DATA_W-1:0] rx_shift, rx_word;
  logic [P_DATA_W-1:0] tx_shift, hold_data, load_word;
  logic                hold_full, miso_q, underrun_q;

  function automatic logic first_bit(input logic [P_DATA_W-1:0] w);
    return LSB_L ? w[0] : w[P_DATA_W-1];
  endfunction

  function automatic logic [P_DATA_W-1:0] shift_out(input logic [P_DATA_W-1:0] w);
    return LSB_L ? (w >> 1) : (w << 1);
  endfunction

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sck_sync  <= {2{CPOL_L}};
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      sck_d     <= CPOL_L;
      cs_d      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[0], i_spi_s_sck};
      cs_sync   <= {cs_sync[0], i_spi_s_cs_n};
      mosi_sync <= {mosi_sync[0], i_spi_s_mosi};
      sck_d     <= sck_sync[1];
      cs_d      <= cs_sync[1];
    end
  end

  assign sck_s  = sck_sync[1];
  assign cs_s   = cs_sync[1];
  assign mosi_s = mosi_sync[1];

  // Edges only count while selected; after reset CSn reads high until a fresh falling edge.
  assign sck_rise    = sck_s & ~sck_d;
  assign sck_fall    = ~sck_s & sck_d;
  assign lead_edge   = CPOL_L ? sck_fall : sck_rise;
  assign trail_edge  = CPOL_L ? sck_rise : sck_fall;
  assign sample_edge = ~cs_s & (CPHA_L ? trail_edge : lead_edge);
  assign shift_edge  = ~cs_s & (CPHA_L ? lead_edge : trail_edge);
  assign cs_fall     = cs_d & ~cs_s;

  assign last_bit   = (bit_cnt == CNT_W'(P_DATA_W - 1));
  assign word_done  = sample_edge & last_bit;
  assign word_start = cs_fall | word_done;
  assign rx_word    = LSB_L ? {mosi_s, rx_shift[P_DATA_W-1:1]} : {rx_shift[P_DATA_W-2:0], mosi_s};
  assign load_word  = hold_full ? hold_data : '0;
  assign tx_write   = i_tx_valid & ~hold_full;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
    end else if (cs_s) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
    end else if (sample_edge) begin
      rx_shift <= rx_word;
      bit_cnt  <= last_bit ? '0 : bit_cnt + CNT_W'(1);
    end
  end

  // In mode 0 the first bit goes out at CS fall; otherwise the next shift edge presents it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tx_shift   <= '0;
      miso_q     <= 1'b0;
      hold_data  <= '0;
      hold_full  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= word_start & ~hold_full;
      if (cs_s) begin
        tx_shift <= '0;
        miso_q   <= 1'b0;
      end else if (word_start) begin
        if (cs_fall && !CPHA_L) begin
          miso_q   <= first_bit(load_word);
          tx_shift <= shift_out(load_word);
        end else begin
          tx_shift <= load_word;
        end
      end else if (shift_edge) begin
        miso_q   <= first_bit(tx_shift);
        tx_shift <= shift_out(tx_shift);
      end
      if (word_start) hold_full <= 1'b0;
      if (tx_write) begin
        hold_data <= i_tx_data;
        hold_full <= 1'b1;
      end
    end
  end

  assign o_spi_s_miso    = miso_q;
  assign o_spi_s_miso_oe = ~cs_s;
  assign o_busy          = ~cs_s;
  assign o_tx_ready      = ~hold_full;
  assign o_tx_underrun   = underrun_q;

`ifdef SPI_SLAVE_CFG_RX_FIFO_EN
  logic [P_DATA_W-1:0] fifo_mem [4];
  logic [1:0]          wr_ptr, rd_ptr;
  logic [2:0]          fifo_cnt;
  logic                fifo_full, pop, push_ok, overrun_q;

  assign o_rx_valid = (fifo_cnt != 3'd0);
  assign fifo_full  = (fifo_cnt == 3'd4);
  assign pop        = o_rx_valid & i_rx_ready;
  assign push_ok    = word_done & (~fifo_full | pop);
  assign o_rx_data  = fifo_mem[rd_ptr];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= word_done & fifo_full & ~pop;
      if (push_ok) begin
        fifo_mem[wr_ptr] <= rx_word;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      fifo_cnt <= fifo_cnt + {2'b00, push_ok} - {2'b00, pop};
    end
  end
  assign o_rx_overrun = overrun_q;
`else
  logic [P_DATA_W-1:0] rx_data_q;
  logic                rx_valid_q, consume, overrun_q;

  assign consume = rx_valid_q & i_rx_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      overrun_q <= word_done & rx_valid_q & ~consume;
      if (word_done && (!rx_valid_q || consume)) begin
        rx_data_q  <= rx_word;
        rx_valid_q <= 1'b1;
      end else if (consume) begin
        rx_valid_q <= 1'b0;
      end
    end
  end
  assign o_rx_data    = rx_data_q;
  assign o_rx_valid   = rx_valid_q;
  assign o_rx_overrun = overrun_q;
`endif

endmodule

// File: tb/tb_spi_slave_cfg.sv
// Directed bench for spi_slave_cfg: mode 0 / 8-bit MSB-first instance and mode 3 / 16-bit LSB-first instance.
module tb_spi_slave_cfg;

  localparam int HALF = 8;
`ifdef SPI_SLAVE_CFG_RX_FIFO_EN
  localparam int EXP_HELD = 4;
  localparam int EXP_OVR  = 1;
`else
  localparam int EXP_HELD = 1;
  localparam int EXP_OVR  = 4;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  logic       sck1 = 1'b0, cs1 = 1'b1, mosi1 = 1'b0, miso1, oe1;
  logic [7:0] txd1 = '0, rxd1;
  logic       txv1 = 1'b0, txr1, rxv1, rxr1 = 1'b1, ovr1, und1, busy1;

  logic        sck2 = 1'b1, cs2 = 1'b1, mosi2 = 1'b0, miso2, oe2;
  logic [15:0] txd2 = '0, rxd2;
  logic        txv2 = 1'b0, txr2, rxv2, rxr2 = 1'b1, ovr2, und2, busy2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];

  spi_slave_cfg u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_spi_s_sck(sck1), .i_spi_s_cs_n(cs1), .i_spi_s_mosi(mosi1),
    .o_spi_s_miso(miso1), .o_spi_s_miso_oe(oe1), .i_tx_data(txd1), .i_tx_valid(txv1),
    .o_tx_ready(txr1), .o_rx_data(rxd1), .o_rx_valid(rxv1), .i_rx_ready(rxr1),
    .o_rx_overrun(ovr1), .o_tx_underrun(und1), .o_busy(busy1)
  );

  spi_slave_cfg #(.P_DATA_W(16), .P_CPOL(1), .P_CPHA(1), .P_LSB_FIRST(1)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_spi_s_sck(sck2), .i_spi_s_cs_n(cs2), .i_spi_s_mosi(mosi2),
    .o_spi_s_miso(miso2), .o_spi_s_miso_oe(oe2), .i_tx_data(txd2), .i_tx_valid(txv2),
    .o_tx_ready(txr2), .o_rx_data(rxd2), .o_rx_valid(rxv2), .i_rx_ready(rxr2),
    .o_rx_overrun(ovr2), .o_tx_underrun(und2), .o_busy(busy2)
  );

  // Monitor: counts pulses and records every consumed RX word.
  int         hs1 = 0, vcyc1 = 0, ovr_n1 = 0, und_n1 = 0, hs2 = 0;
  logic [7:0]  got1 [0:63];
  logic [15:0] got2 [0:7];

  always @(negedge clk) begin
    if (rxv1) vcyc1 <= vcyc1 + 1;
    if (rxv1 && rxr1) begin
      got1[hs1 % 64] <= rxd1;
      hs1 <= hs1 + 1;
    end
    if (ovr1) ovr_n1 <= ovr_n1 + 1;
    if (und1) und_n1 <= und_n1 + 1;
    if (rxv2 && rxr2) begin
      got2[hs2 % 8] <= rxd2;
      hs2 <= hs2 + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic load_tx1(input logic [7:0] d);
    txd1 = d;
    txv1 = 1'b1;
    tick(1);
    txv1 = 1'b0;
  endtask

  // Mode 0 master: data set while SCK low, both sides sample on the rising edge.
  task automatic m1_word(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi1 = tx[7-i];
      tick(HALF);
      rx[7-i] = miso1;
      sck1 = 1'b1;
      tick(HALF);
      sck1 = 1'b0;
    end
  endtask

  // Mode 3 master, LSB first: data changes on the falling edge, sampled on the rising edge.
  task automatic m2_word(input logic [15:0] tx, output logic [15:0] rx);
    rx = '0;
    for (int i = 0; i < 16; i++) begin
      sck2 = 1'b0;
      mosi2 = tx[i];
      tick(HALF);
      rx[i] = miso2;
      sck2 = 1'b1;
      tick(HALF);
    end
  endtask

  task automatic test_reset;
    tick(3);
    n_checks++; if (miso1 !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b expected 0", miso1); end
    n_checks++; if (oe1 !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b expected 0", oe1); end
    n_checks++; if (txr1 !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready: got %b expected 1", txr1); end
    n_checks++; if (rxv1 !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b expected 0", rxv1); end
    n_checks++; if (rxd1 !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h expected 00", rxd1); end
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy1); end
    n_checks++; if ({ovr1, und1} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b expected 00", {ovr1, und1}); end
    n_checks++; if (txr2 !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready2: got %b expected 1", txr2); end
    rst = 1'b0;
    tick(4);
  endtask

  task automatic test_basic;
    logic [7:0] rx;
    int h0, v0;
    load_tx1(8'h55);
    n_checks++; if (txr1 !== 1'b0) begin n_fail++; $display("FAIL basic_tx_ready_full: got %b expected 0", txr1); end
    h0 = hs1; v0 = vcyc1;
    cs1 = 1'b0;
    tick(HALF);
    n_checks++; if ({busy1, oe1} !== 2'b11) begin n_fail++; $display("FAIL basic_busy_oe: got %b expected 11", {busy1, oe1}); end
    m1_word(8'hAA, 8, rx);
    tick(HALF);
    cs1 = 1'b1;
    tick(HALF);
    n_checks++; if (rx !== 8'h55) begin n_fail++; $display("FAIL basic_miso_word: got %h expected 55", rx); end
    n_checks++; if (hs1 - h0 !== 1) begin n_fail++; $display("FAIL basic_rx_count: got %0d expected 1", hs1 - h0); end
    n_checks++; if (got1[h0 % 64] !== 8'hAA) begin n_fail++; $display("FAIL basic_rx_data: got %h expected aa", got1[h0 % 64]); end
    n_checks++; if (vcyc1 - v0 !== 1) begin n_fail++; $display("FAIL basic_valid_cycles: got %0d expected 1", vcyc1 - v0); end
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL basic_busy_idle: got %b expected 0", busy1); end
  endtask

  task automatic test_mode3_lsb16;
    logic [15:0] rx;
    int h0;
    h0 = hs2;
    txd2 = 16'hBEEF;
    txv2 = 1'b1;
    tick(1);
    txv2 = 1'b0;
    cs2 = 1'b0;
    tick(HALF);
    m2_word(16'h1234, rx);
    tick(HALF);
    cs2 = 1'b1;
    tick(HALF);
    n_checks++; if (rx !== 16'hBEEF) begin n_fail++; $display("FAIL mode3_miso_word: got %h expected beef", rx); end
    n_checks++; if (hs2 - h0 !== 1) begin n_fail++; $display("FAIL mode3_rx_count: got %0d expected 1", hs2 - h0); end
    n_checks++; if (got2[h0 % 8] !== 16'h1234) begin n_fail++; $display("FAIL mode3_rx_data: got %h expected 1234", got2[h0 % 8]); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] r0, r1, r2, e;
    int h0, u0;
    load_tx1(8'hA5);
    h0 = hs1; u0 = und_n1;
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    cs1 = 1'b0;
    tick(HALF);
    m1_word(8'h11, 8, r0);
    m1_word(8'h22, 8, r1);
    n_checks++; if (und_n1 - u0 !== 2) begin n_fail++; $display("FAIL b2b_underrun_pulses: got %0d expected 2", und_n1 - u0); end
    m1_word(8'h33, 8, r2);
    tick(HALF);
    cs1 = 1'b1;
    tick(HALF);
    n_checks++; if (r0 !== 8'hA5) begin n_fail++; $display("FAIL b2b_miso_w0: got %h expected a5", r0); end
    n_checks++; if (r1 !== 8'h00) begin n_fail++; $display("FAIL b2b_miso_w1: got %h expected 00", r1); end
    n_checks++; if (r2 !== 8'h00) begin n_fail++; $display("FAIL b2b_miso_w2: got %h expected 00", r2); end
    n_checks++; if (hs1 - h0 !== 3) begin n_fail++; $display("FAIL b2b_rx_count: got %0d expected 3", hs1 - h0); end
    for (int k = 0; k < 3; k++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got1[(h0 + k) % 64] !== e) begin n_fail++; $display("FAIL b2b_rx_data%0d: got %h expected %h", k, got1[(h0 + k) % 64], e); end
    end
  endtask

  task automatic test_rx_overrun;
    logic [7:0] words [5];
    logic [7:0] rx;
    int h0, o0;
    words[0] = 8'h3C; words[1] = 8'h5A; words[2] = 8'h96; words[3] = 8'hE1; words[4] = 8'h7F;
    rxr1 = 1'b0;
    h0 = hs1; o0 = ovr_n1;
    cs1 = 1'b0;
    tick(HALF);
    for (int k = 0; k < 5; k++) m1_word(words[k], 8, rx);
    tick(HALF);
    cs1 = 1'b1;
    tick(HALF);
    n_checks++; if (ovr_n1 - o0 !== EXP_OVR) begin n_fail++; $display("FAIL ovr_pulses: got %0d expected %0d", ovr_n1 - o0, EXP_OVR); end
    n_checks++; if (rxv1 !== 1'b1) begin n_fail++; $display("FAIL ovr_valid_held: got %b expected 1", rxv1); end
    n_checks++; if (rxd1 !== 8'h3C) begin n_fail++; $display("FAIL ovr_head_stable: got %h expected 3c", rxd1); end
    rxr1 = 1'b1;
    tick(8);
    n_checks++; if (hs1 - h0 !== EXP_HELD) begin n_fail++; $display("FAIL ovr_drained: got %0d expected %0d", hs1 - h0, EXP_HELD); end
    for (int k = 0; k < EXP_HELD; k++) begin
      n_checks++;
      if (got1[(h0 + k) % 64] !== words[k]) begin n_fail++; $display("FAIL ovr_data%0d: got %h expected %h", k, got1[(h0 + k) % 64], words[k]); end
    end
  endtask

  task automatic test_cs_abort;
    logic [7:0] rx;
    int h0;
    h0 = hs1;
    cs1 = 1'b0;
    tick(HALF);
    m1_word(8'hFF, 5, rx);
    tick(HALF);
    cs1 = 1'b1;
    tick(2 * HALF);
    n_checks++; if (hs1 !== h0) begin n_fail++; $display("FAIL abort_partial_out: got %0d words expected 0", hs1 - h0); end
    cs1 = 1'b0;
    tick(HALF);
    m1_word(8'hC3, 8, rx);
    tick(HALF);
    cs1 = 1'b1;
    tick(HALF);
    n_checks++; if (hs1 - h0 !== 1) begin n_fail++; $display("FAIL abort_rx_count: got %0d expected 1", hs1 - h0); end
    n_checks++; if (got1[h0 % 64] !== 8'hC3) begin n_fail++; $display("FAIL abort_rx_data: got %h expected c3", got1[h0 % 64]); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] rx;
    int h0;
    load_tx1(8'h0F);
    cs1 = 1'b0;
    tick(HALF);
    m1_word(8'hF0, 3, rx);
    tick(2);
    rst = 1'b1;
    #1;
    n_checks++; if ({miso1, oe1, busy1} !== 3'b000) begin n_fail++; $display("FAIL rstmid_miso_oe_busy: got %b expected 000", {miso1, oe1, busy1}); end
    n_checks++; if (txr1 !== 1'b1) begin n_fail++; $display("FAIL rstmid_tx_ready: got %b expected 1", txr1); end
    n_checks++; if ({rxv1, rxd1} !== 9'h000) begin n_fail++; $display("FAIL rstmid_rx_stage: got %h expected 000", {rxv1, rxd1}); end
    n_checks++; if ({ovr1, und1} !== 2'b00) begin n_fail++; $display("FAIL rstmid_pulses: got %b expected 00", {ovr1, und1}); end
    tick(2);
    rst = 1'b0;
    tick(HALF);
    cs1 = 1'b1;
    tick(2 * HALF);
    load_tx1(8'h69);
    h0 = hs1;
    cs1 = 1'b0;
    tick(HALF);
    m1_word(8'h96, 8, rx);
    tick(HALF);
    cs1 = 1'b1;
    tick(HALF);
    n_checks++; if (rx !== 8'h69) begin n_fail++; $display("FAIL rstmid_after_miso: got %h expected 69", rx); end
    n_checks++; if (hs1 - h0 !== 1) begin n_fail++; $display("FAIL rstmid_after_count: got %0d expected 1", hs1 - h0); end
    n_checks++; if (got1[h0 % 64] !== 8'h96) begin n_fail++; $display("FAIL rstmid_after_data: got %h expected 96", got1[h0 % 64]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mode3_lsb16();
    test_back_to_back();
    test_rx_overrun();
    test_cs_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
